// File: rtl/issue_ctrl_pkg.sv
// Shared issue-stage definitions: instruction-buffer entry layout, op and branch
// classifications, and widths used by issue_ctrl and its scoreboard.
package issue_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OPC_W    = 8;
    localparam int unsigned WB_PORTS = 2;
    localparam int unsigned PERF_W   = 32;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_MUL    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_CSR    = 3'd5
    } optype_t;

    typedef logic [OPC_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JUMP = 2'd2,
        BR_RET  = 2'd3
    } br_type_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        optype_t           optype;
        opcode_t           opcode;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] r1;
        logic [REG_AW-1:0] r2;
        logic              src2_is_imm;
        logic              is_spec_op;
        logic              have_excp;
        br_type_t          br_type;
        logic [XLEN-1:0]   imm;
    } ibuf_entry_t;

    // Loads and stores share the single memory pipe.
    function automatic logic is_mem_op(optype_t t);
        return (t == OP_LOAD) || (t == OP_STORE);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Load scoreboard: one busy bit per architectural register for loads in flight.
// Ports:
//   clk, resetn         clock, async active-low reset
//   flush               clears every busy bit on the next edge
//   set_valid/set_dest  mark a register busy (wins over a same-cycle clear)
//   clr_valid/clr_dest  per-writeback-port clears
//   qa_*/qb_*           hazard queries for slots A and B (combinational)
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              flush,
    input  logic                              set_valid,
    input  logic [REG_AW-1:0]                 set_dest,
    input  logic [WB_PORTS-1:0]               clr_valid,
    input  logic [WB_PORTS-1:0][REG_AW-1:0]   clr_dest,
    input  logic [REG_AW-1:0]                 qa_r1,
    input  logic [REG_AW-1:0]                 qa_r2,
    input  logic                              qa_r2_en,
    output logic                              qa_hazard_c,
    input  logic [REG_AW-1:0]                 qb_r1,
    input  logic [REG_AW-1:0]                 qb_r2,
    input  logic                              qb_r2_en,
    output logic                              qb_hazard_c
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Next busy vector: clears first, then sets so a set wins; r0 never busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < int'(WB_PORTS); i++) begin
            if (clr_valid[i]) begin
                clr_mask[clr_dest[i]] = 1'b1;
            end
        end
        if (set_valid) begin
            set_mask[set_dest] = 1'b1;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
        if (flush) begin
            busy_next = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard queries read the registered vector only; no writeback bypass.
    always_comb begin
        qa_hazard_c = busy[qa_r1] | (qa_r2_en & busy[qa_r2]);
        qb_hazard_c = busy[qb_r1] | (qb_r2_en & busy[qb_r2]);
    end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue controller: selects 0/1/2 entries from the instruction buffer head
// into a one-deep issue register (slots A, B), tracking in-flight loads.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   flush                       synchronous pipeline flush
//   a_valid/a_entry             buffer head entry
//   b_valid/b_entry             second buffer entry
//   pop_size                    entries consumed this cycle (combinational)
//   ex_ready                    execute stage accepts the issue register
//   ex_a_valid/ex_a_entry       issue slot A
//   ex_b_valid/ex_b_entry       issue slot B
//   wb_valid/wb_dest            load writeback strobes and registers
// Optional (ISSUE_PERF_EN defined): perf_dual, perf_single, perf_stall cycle counters.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic                             a_valid,
    input  logic                             b_valid,
    input  ibuf_entry_t                      a_entry,
    input  ibuf_entry_t                      b_entry,
    output logic [1:0]                       pop_size,
    input  logic                             ex_ready,
    output logic                             ex_a_valid,
    output logic                             ex_b_valid,
    output ibuf_entry_t                      ex_a_entry,
    output ibuf_entry_t                      ex_b_entry,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS-1:0][REG_AW-1:0]  wb_dest
`ifdef ISSUE_PERF_EN
    ,
    output logic [PERF_W-1:0]                perf_dual,
    output logic [PERF_W-1:0]                perf_single,
    output logic [PERF_W-1:0]                perf_stall
`endif
);

    logic free_c;
    logic haz_a_c;
    logic haz_b_c;
    logic b_reads_a_c;
    logic pair_ok_c;
    logic issue_a_c;
    logic issue_b_c;
    logic a_load_c;
    logic b_load_c;
    logic set_valid_c;
    logic [REG_AW-1:0] set_dest_c;

    issue_scoreboard u_scoreboard (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .set_valid   (set_valid_c),
        .set_dest    (set_dest_c),
        .clr_valid   (wb_valid),
        .clr_dest    (wb_dest),
        .qa_r1       (a_entry.r1),
        .qa_r2       (a_entry.r2),
        .qa_r2_en    (!a_entry.src2_is_imm),
        .qa_hazard_c (haz_a_c),
        .qb_r1       (b_entry.r1),
        .qb_r2       (b_entry.r2),
        .qb_r2_en    (!b_entry.src2_is_imm),
        .qb_hazard_c (haz_b_c)
    );

    // Issue selection; reset and flush both force pop_size to zero.
    always_comb begin
        free_c      = !ex_a_valid || ex_ready;
        b_reads_a_c = (a_entry.dest != '0) &&
                      ((b_entry.r1 == a_entry.dest) ||
                       (!b_entry.src2_is_imm && (b_entry.r2 == a_entry.dest)));
        pair_ok_c   = !a_entry.is_spec_op && !b_entry.is_spec_op &&
                      !a_entry.have_excp  && !b_entry.have_excp  &&
                      (a_entry.br_type == BR_NONE) &&
                      !(is_mem_op(a_entry.optype) && is_mem_op(b_entry.optype)) &&
                      !b_reads_a_c;
        issue_a_c   = resetn && !flush && a_valid && free_c && !haz_a_c;
        issue_b_c   = issue_a_c && b_valid && !haz_b_c && pair_ok_c;
        if (issue_b_c) begin
            pop_size = 2'd2;
        end else if (issue_a_c) begin
            pop_size = 2'd1;
        end else begin
            pop_size = 2'd0;
        end
    end

    // At most one memory op issues per cycle, so a single set port suffices.
    always_comb begin
        a_load_c    = issue_a_c && (a_entry.optype == OP_LOAD) && (a_entry.dest != '0);
        b_load_c    = issue_b_c && (b_entry.optype == OP_LOAD) && (b_entry.dest != '0);
        set_valid_c = a_load_c || b_load_c;
        set_dest_c  = a_load_c ? a_entry.dest : b_entry.dest;
    end

    // Issue register valids: reload whenever free, hold while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_a_valid <= 1'b0;
            ex_b_valid <= 1'b0;
        end else if (flush) begin
            ex_a_valid <= 1'b0;
            ex_b_valid <= 1'b0;
        end else if (free_c) begin
            ex_a_valid <= issue_a_c;
            ex_b_valid <= issue_b_c;
        end
    end

    // Payloads load only on issue (which implies free), so they hold on stall.
    always_ff @(posedge clk) begin
        if (issue_a_c) begin
            ex_a_entry <= a_entry;
        end
        if (issue_b_c) begin
            ex_b_entry <= b_entry;
        end
    end

`ifdef ISSUE_PERF_EN
    // Issue-width histogram over cycles where the buffer head is present.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_dual   <= '0;
            perf_single <= '0;
            perf_stall  <= '0;
        end else if (a_valid) begin
            case (pop_size)
                2'd2:    perf_dual   <= perf_dual + PERF_W'(1);
                2'd1:    perf_single <= perf_single + PERF_W'(1);
                default: perf_stall  <= perf_stall + PERF_W'(1);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    logic a_valid, b_valid;
    ibuf_entry_t a_entry, b_entry;
    logic [1:0] pop_size;
    logic ex_ready;
    logic ex_a_valid, ex_b_valid;
    ibuf_entry_t ex_a_entry, ex_b_entry;
    logic [1:0] wb_valid;
    logic [1:0][4:0] wb_dest;
`ifdef ISSUE_PERF_EN
    logic [31:0] perf_dual, perf_single, perf_stall;
`endif

    issue_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .a_entry    (a_entry),
        .b_entry    (b_entry),
        .pop_size   (pop_size),
        .ex_ready   (ex_ready),
        .ex_a_valid (ex_a_valid),
        .ex_b_valid (ex_b_valid),
        .ex_a_entry (ex_a_entry),
        .ex_b_entry (ex_b_entry),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest)
`ifdef ISSUE_PERF_EN
        ,
        .perf_dual  (perf_dual),
        .perf_single(perf_single),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_ep = 0;

    // Behavioural model state
    bit          m_a_valid, m_b_valid;
    ibuf_entry_t m_a_entry, m_b_entry;
    bit          m_busy [32];
    int unsigned m_dual, m_single, m_stall;

    ibuf_entry_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit blocked(ibuf_entry_t e);
        bit r1_busy = (e.r1 != 0) && m_busy[e.r1];
        bit r2_busy = !e.src2_is_imm && (e.r2 != 0) && m_busy[e.r2];
        return r1_busy || r2_busy;
    endfunction

    function automatic bit is_mem(ibuf_entry_t e);
        return e.optype == OP_LOAD || e.optype == OP_STORE;
    endfunction

    // How many entries the rules allow to leave the buffer this cycle.
    function automatic int model_pop();
        if (!resetn || flush || !a_valid) return 0;
        if (m_a_valid && !ex_ready) return 0;
        if (blocked(a_entry)) return 0;
        if (!b_valid || blocked(b_entry)) return 1;
        if (a_entry.is_spec_op || b_entry.is_spec_op) return 1;
        if (a_entry.have_excp || b_entry.have_excp) return 1;
        if (a_entry.br_type != BR_NONE) return 1;
        if (is_mem(a_entry) && is_mem(b_entry)) return 1;
        if (a_entry.dest != 0 && (b_entry.r1 == a_entry.dest ||
            (!b_entry.src2_is_imm && b_entry.r2 == a_entry.dest))) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_a_valid = 0;
        m_b_valid = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_dual = 0;
        m_single = 0;
        m_stall = 0;
    endtask

    task automatic model_edge(input int ep);
        if (a_valid) begin
            if (ep == 2) m_dual++;
            else if (ep == 1) m_single++;
            else m_stall++;
        end
        if (flush) begin
            m_a_valid = 0;
            m_b_valid = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            for (int i = 0; i < 2; i++) if (wb_valid[i]) m_busy[wb_dest[i]] = 0;
            if (ep >= 1 && a_entry.optype == OP_LOAD && a_entry.dest != 0) m_busy[a_entry.dest] = 1;
            if (ep == 2 && b_entry.optype == OP_LOAD && b_entry.dest != 0) m_busy[b_entry.dest] = 1;
            if (!m_a_valid || ex_ready) begin
                m_a_valid = (ep >= 1);
                m_b_valid = (ep == 2);
                if (ep >= 1) m_a_entry = a_entry;
                if (ep == 2) m_b_entry = b_entry;
            end
        end
    endtask

    // Called shortly after inputs change (between edges): compare DUT with model.
    task automatic pre();
        #1;
        cur_ep = model_pop();
        chk("pop_size", 128'(pop_size), 128'(cur_ep));
        chk("ex_a_valid", 128'(ex_a_valid), 128'(m_a_valid));
        chk("ex_b_valid", 128'(ex_b_valid), 128'(m_b_valid));
        if (m_a_valid) chk("ex_a_entry", 128'(ex_a_entry), 128'(m_a_entry));
        if (m_b_valid) chk("ex_b_entry", 128'(ex_b_entry), 128'(m_b_entry));
`ifdef ISSUE_PERF_EN
        chk("perf_dual", 128'(perf_dual), 128'(m_dual));
        chk("perf_single", 128'(perf_single), 128'(m_single));
        chk("perf_stall", 128'(perf_stall), 128'(m_stall));
`endif
    endtask

    task automatic post();
        @(posedge clk);
        model_edge(cur_ep);
        @(negedge clk);
    endtask

    function automatic ibuf_entry_t mk(optype_t t, logic [4:0] d, logic [4:0] r1,
                                       logic [4:0] r2, logic imm);
        ibuf_entry_t e = '0;
        e.pc = 32'h0000_1000 + 32'(d) * 4;
        e.optype = t;
        e.opcode = 8'h33;
        e.dest = d;
        e.r1 = r1;
        e.r2 = r2;
        e.src2_is_imm = imm;
        e.br_type = BR_NONE;
        e.imm = 32'h0000_00a5;
        return e;
    endfunction

    function automatic ibuf_entry_t rand_entry();
        ibuf_entry_t e;
        e.pc = $urandom();
        e.optype = optype_t'(3'($urandom_range(0, 5)));
        e.opcode = 8'($urandom());
        e.dest = 5'($urandom_range(0, 7));
        e.r1 = 5'($urandom_range(0, 7));
        e.r2 = 5'($urandom_range(0, 7));
        e.src2_is_imm = 1'($urandom_range(0, 1));
        e.is_spec_op = ($urandom_range(0, 15) == 0);
        e.have_excp = ($urandom_range(0, 15) == 0);
        e.br_type = (e.optype == OP_BRANCH) ? br_type_t'(2'($urandom_range(1, 3))) : BR_NONE;
        e.imm = $urandom();
        return e;
    endfunction

    task automatic idle_inputs();
        flush = 0;
        a_valid = 0;
        b_valid = 0;
        ex_ready = 1;
        wb_valid = 2'b00;
        wb_dest = '0;
    endtask

    ibuf_entry_t p_a, p_b;
    int avail;

    initial begin
        resetn = 0;
        idle_inputs();
        a_entry = mk(OP_ALU, 5'd1, 5'd2, 5'd3, 1'b0);
        b_entry = mk(OP_ALU, 5'd4, 5'd5, 5'd6, 1'b0);
        a_valid = 1;
        model_reset();
        #1;
        chk("reset_pop", 128'(pop_size), 128'(0));
        chk("reset_a_valid", 128'(ex_a_valid), 128'(0));
        chk("reset_b_valid", 128'(ex_b_valid), 128'(0));
        @(negedge clk);
        resetn = 1;

        // Independent ALU pair dual-issues on the first edge after reset
        a_valid = 1; b_valid = 1; ex_ready = 1;
        pre();
        chk("dual_pop", 128'(pop_size), 128'(2));
        post();
        chk("dual_a_valid", 128'(ex_a_valid), 128'(1));
        chk("dual_b_valid", 128'(ex_b_valid), 128'(1));

        // RAW within the pair: only A goes, B follows alone
        a_entry = mk(OP_ALU, 5'd5, 5'd1, 5'd2, 1'b0);
        b_entry = mk(OP_ALU, 5'd6, 5'd5, 5'd0, 1'b1);
        pre();
        chk("raw_pop", 128'(pop_size), 128'(1));
        post();
        a_entry = mk(OP_ALU, 5'd6, 5'd5, 5'd0, 1'b1);
        b_valid = 0;
        pre();
        chk("raw_b_alone_pop", 128'(pop_size), 128'(1));
        post();
        chk("raw_b_alone_valid", 128'(ex_b_valid), 128'(0));
        chk("raw_b_alone_dest", 128'(ex_a_entry.dest), 128'(6));

        // Load-use: reader of r7 waits for the writeback, then issues next cycle
        a_entry = mk(OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b1);
        pre();
        chk("load_pop", 128'(pop_size), 128'(1));
        post();
        a_entry = mk(OP_ALU, 5'd8, 5'd7, 5'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pre();
            chk("load_use_stall", 128'(pop_size), 128'(0));
            post();
        end
        wb_valid = 2'b01; wb_dest[0] = 5'd7;
        pre();
        chk("load_wb_cycle", 128'(pop_size), 128'(0));
        post();
        wb_valid = 2'b00;
        pre();
        chk("load_after_wb", 128'(pop_size), 128'(1));
        post();

        // Back-pressure: full register held for three cycles
        p_a = mk(OP_ALU, 5'd9, 5'd1, 5'd2, 1'b0);
        p_b = mk(OP_MUL, 5'd10, 5'd3, 5'd4, 1'b0);
        a_entry = p_a; b_entry = p_b; b_valid = 1;
        pre();
        post();
        ex_ready = 0;
        a_entry = mk(OP_ALU, 5'd11, 5'd1, 5'd1, 1'b0);
        b_entry = mk(OP_ALU, 5'd12, 5'd2, 5'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pre();
            chk("stall_pop", 128'(pop_size), 128'(0));
            post();
            chk("stall_a_payload", 128'(ex_a_entry), 128'(p_a));
            chk("stall_b_payload", 128'(ex_b_entry), 128'(p_b));
        end
        ex_ready = 1;

        // Flush drops valids and clears a pending r3 load
        a_entry = mk(OP_LOAD, 5'd3, 5'd1, 5'd0, 1'b1);
        b_valid = 0;
        pre();
        post();
        a_entry = mk(OP_ALU, 5'd13, 5'd3, 5'd0, 1'b1);
        flush = 1;
        pre();
        chk("flush_pop", 128'(pop_size), 128'(0));
        post();
        flush = 0;
        chk("flush_a_valid", 128'(ex_a_valid), 128'(0));
        pre();
        chk("flush_r3_reader", 128'(pop_size), 128'(1));
        post();

        // Reset asserted in the middle of a stall
        a_entry = p_a; b_entry = p_b; b_valid = 1;
        pre();
        post();
        ex_ready = 0;
        pre();
        post();
        #2 resetn = 0;
        #1;
        model_reset();
        chk("rst_mid_a_valid", 128'(ex_a_valid), 128'(0));
        chk("rst_mid_b_valid", 128'(ex_b_valid), 128'(0));
        chk("rst_mid_pop", 128'(pop_size), 128'(0));
`ifdef ISSUE_PERF_EN
        chk("rst_perf_dual", 128'(perf_dual), 128'(0));
        chk("rst_perf_single", 128'(perf_single), 128'(0));
        chk("rst_perf_stall", 128'(perf_stall), 128'(0));
`endif
        @(negedge clk);
        resetn = 1;
        ex_ready = 1;
        pre();
        chk("post_reset_pop", 128'(pop_size), 128'(2));
        post();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            while (q.size() < 4) q.push_back(rand_entry());
            avail = int'($urandom_range(0, 2));
            a_valid = (avail >= 1);
            b_valid = (avail >= 2);
            a_entry = q[0];
            b_entry = q[1];
            flush = ($urandom_range(0, 49) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                wb_valid[i] = ($urandom_range(0, 2) == 0);
                wb_dest[i] = 5'($urandom_range(0, 7));
            end
            pre();
            post();
            for (int k = 0; k < cur_ep; k++) void'(q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk  in  1  sole clock, all state on rising edge
  resetn  in  1  asynchronous, active-low reset
  flush  in  1  pipeline flush, synchronous
  a_valid  in  1  queue head entry present
  b_valid  in  1  second entry present; never 1 while a_valid is 0
  a_entry  in  ibuf_entry_t  head entry: pc, optype, opcode, dest, r1, r2, src2_is_imm, is_spec_op, have_excp, br_type, ...
  b_entry  in  ibuf_entry_t  second entry, same format
  pop_size  out  2  entries consumed this cycle (0/1/2), combinational
  ex_ready  in  1  execute stage accepts the issue register
  ex_a_valid  out  1  issue slot A holds an instruction
  ex_b_valid  out  1  issue slot B holds an instruction
  ex_a_entry  out  ibuf_entry_t  registered slot A payload
  ex_b_entry  out  ibuf_entry_t  registered slot B payload
  wb_valid  in  2  per-port load writeback strobes
  wb_dest  in  2x5  per-port load writeback register

Function
REQ-002 SHALL hold a one-deep issue register (slots A, B); it is free when empty or ex_ready=1.
REQ-003 SHALL keep a 32-bit load scoreboard; bit n=1 means a load to rn is in flight; bit 0 always reads 0.
REQ-004 SHALL treat A as issuable when a_valid, register free, and neither r1 nor r2 (r2 only if src2_is_imm=0) hits a set scoreboard bit.
REQ-005 SHALL treat B as issuable only when A issues, b_valid, B passes REQ-004, and none of: A or B is_spec_op, A or B have_excp, A is a branch (br_type != none), A and B both memory ops, B reads A.dest with A.dest != 0.
REQ-006 SHALL drive pop_size = 0, 1 or 2 from REQ-004/005 in the same cycle; never 2 without A issuing.
REQ-007 SHALL load issued entries into the issue register on the next edge; slot B valid only if B issued.
REQ-008 SHALL clear the issue register valids when it is free and pop_size=0.
REQ-009 SHALL hold issue register contents unchanged while ex_ready=0 and valid.
REQ-010 SHALL set scoreboard bit on issue of a load with dest != 0, clear on wb_valid[i] for wb_dest[i].
REQ-011 SHALL give set priority over clear for the same register in the same cycle.
REQ-012 SHALL, on flush, clear both valids and the whole scoreboard next edge and force pop_size=0 that cycle.

Reset
REQ-013 SHALL, with resetn=0, immediately clear ex_a_valid, ex_b_valid, scoreboard, and counters; pop_size=0; payload registers need no reset.
REQ-014 SHALL resume issuing on the first edge after resetn deasserts, with no extra idle cycle.

Configuration
REQ-015 SHALL, when ISSUE_PERF_EN is defined, add outputs perf_dual, perf_single, and perf_stall (32 bits each, wrapping); each counts cycles with pop_size 2, 1, or 0 while a_valid=1.
REQ-016 SHALL, without ISSUE_PERF_EN, have no such ports and no counter logic.

Structure
REQ-017 SHALL take ibuf_entry_t, optype_t, and br_type_t from the shared definitions package, alongside the existing optype/opcode typedefs.
REQ-018 SHALL place the scoreboard in a sub-module issue_scoreboard with set, clear[2], and hazard-query ports.

Verification
REQ-019 Independent ALU pair, ex_ready=1 -> pop_size=2; both ex valids=1 next cycle.
REQ-020 A: add r5; B: reads r5 -> pop_size=1, then B issues alone next cycle.
REQ-021 Load r7 issued, next entry reads r7 -> pop_size=0 until wb_valid[0] with wb_dest=7, then issues the cycle after.
REQ-022 ex_ready=0 for 3 cycles with a full issue register -> pop_size=0 and payload stable for 3 cycles.
REQ-023 flush with scoreboard r3 set -> valids=0 and r3 clear next cycle; a reader of r3 issues immediately.
REQ-024 resetn pulsed low mid-stall -> valids drop asynchronously; ISSUE_PERF_EN counters read 0.
